// File: rtl/spike_filter_bank.sv
`default_nettype none
// ============================================================================
// Module      : spike_filter_bank
// Description : Bank of Nfilts exponential-decay filters fed by tag/count
//               events. Each filter picks one of Nkern increment/decay
//               kernels. An update_pulse sweeps the active filters, emits each
//               (idx, state) on a valid/ack channel and writes back the
//               decayed state.
//               Optional build macro SPIKE_FILTER_SKIP_ZERO_EN: zero-valued
//               filters are skipped (not emitted) during a sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_filter_bank #(
    parameter int Nfilts = 16,
    parameter int Nstate = 27,
    parameter int Nct    = 10,
    parameter int Nkern  = 4,
    parameter int IdxW   = $clog2(Nfilts),
    parameter int KW     = (Nkern > 1) ? $clog2(Nkern) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     update_pulse,
    input  logic                     in_v,
    output logic                     in_a,
    input  logic [IdxW-1:0]          in_tag,
    input  logic [Nct-1:0]           in_ct,
    output logic                     out_v,
    input  logic                     out_a,
    output logic [IdxW-1:0]          out_idx,
    output logic [Nstate-1:0]        out_state,
    input  logic [IdxW:0]            filts_used,
    input  logic [Nkern*Nstate-1:0]  increment_constant,
    input  logic [Nkern*Nstate-1:0]  decay_constant,
    input  logic [Nfilts*KW-1:0]     kernel_sel,
    output logic                     sweeping,
    output logic [15:0]              dropped_events,
    output logic [15:0]              missed_updates
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SWEEP_RD   = 2'd1;
    localparam logic [1:0] SWEEP_EMIT = 2'd2;

    localparam int SumW = Nct + Nstate + 1;
    localparam logic [Nstate-1:0] STATE_MAX = '1;

    logic [Nstate-1:0]   filt_state [Nfilts];
    logic [1:0]          fsm;
    logic [IdxW:0]       sweep_idx;
    logic                pending;

    logic                start_sweep;
    logic                accept;
    logic                tag_active;
    logic                idx_active;
    logic [IdxW-1:0]     cur;
    logic [KW-1:0]       acc_k;
    logic [KW-1:0]       dec_k;
    logic [Nstate-1:0]   inc_sel;
    logic [Nstate-1:0]   dc_sel;
    logic [Nstate-1:0]   acc_cur;
    logic [Nct+Nstate-1:0] acc_prod;
    logic [SumW-1:0]     acc_sum;
    logic [Nstate-1:0]   acc_next;
    logic [2*Nstate-1:0] decay_prod;
    logic [Nstate-1:0]   decay_next;

    assign cur      = sweep_idx[IdxW-1:0];
    assign sweeping = (fsm == SWEEP_RD) || (fsm == SWEEP_EMIT);

    // A sweep request (fresh or deferred) wins over an input event in IDLE.
    assign start_sweep = (fsm == IDLE) && (pending || update_pulse);
    assign accept      = (fsm == IDLE) && !pending && !update_pulse && in_v && !reset;
    assign in_a        = accept;

    assign tag_active = ({1'b0, in_tag} < filts_used) && (int'(in_tag) < Nfilts);
    assign idx_active = (sweep_idx < filts_used) && (int'(sweep_idx) < Nfilts);

    // Accumulate path: saturating state + count * increment.
    assign acc_k    = kernel_sel[int'(in_tag)*KW +: KW];
    assign inc_sel  = increment_constant[int'(acc_k)*Nstate +: Nstate];
    assign acc_cur  = filt_state[in_tag];
    assign acc_prod = {{Nstate{1'b0}}, in_ct} * {{Nct{1'b0}}, inc_sel};
    assign acc_sum  = {1'b0, acc_prod} + {{(Nct+1){1'b0}}, acc_cur};
    assign acc_next = (acc_sum > {{(Nct+1){1'b0}}, STATE_MAX}) ? STATE_MAX
                                                               : acc_sum[Nstate-1:0];

    // Decay path: Q0.Nstate multiply, truncated.
    assign dec_k      = kernel_sel[int'(cur)*KW +: KW];
    assign dc_sel     = decay_constant[int'(dec_k)*Nstate +: Nstate];
    assign decay_prod = {{Nstate{1'b0}}, filt_state[cur]} * {{Nstate{1'b0}}, dc_sel};
    assign decay_next = decay_prod[2*Nstate-1:Nstate];

    // Filter state storage: accumulate in IDLE, decay write-back on output ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < Nfilts; k++) filt_state[k] <= '0;
        end else if (accept && tag_active) begin
            filt_state[in_tag] <= acc_next;
        end else if ((fsm == SWEEP_EMIT) && out_a) begin
            filt_state[cur] <= decay_next;
        end
    end

    // Sweep sequencer and output channel registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            sweep_idx <= '0;
            out_v     <= 1'b0;
            out_idx   <= '0;
            out_state <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start_sweep) begin
                        fsm       <= SWEEP_RD;
                        sweep_idx <= '0;
                    end
                end
                SWEEP_RD: begin
                    if (!idx_active) begin
                        fsm <= IDLE;
`ifdef SPIKE_FILTER_SKIP_ZERO_EN
                    end else if (filt_state[cur] == '0) begin
                        // Zero filter: nothing to emit and decay leaves it 0.
                        sweep_idx <= sweep_idx + 1'b1;
`endif
                    end else begin
                        out_idx   <= cur;
                        out_state <= filt_state[cur];
                        out_v     <= 1'b1;
                        fsm       <= SWEEP_EMIT;
                    end
                end
                SWEEP_EMIT: begin
                    if (out_a) begin
                        out_v     <= 1'b0;
                        sweep_idx <= sweep_idx + 1'b1;
                        fsm       <= SWEEP_RD;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // Deferred sweep request: one pulse during a sweep is remembered.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (start_sweep) begin
            pending <= 1'b0;
        end else if (sweeping && update_pulse) begin
            pending <= 1'b1;
        end
    end

    // Saturating diagnostic counters for dropped events and lost pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_events <= '0;
            missed_updates <= '0;
        end else begin
            if (accept && !tag_active && (dropped_events != 16'hFFFF))
                dropped_events <= dropped_events + 16'd1;
            if (sweeping && update_pulse && pending && (missed_updates != 16'hFFFF))
                missed_updates <= missed_updates + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spike_filter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_filter_bank
// Description : Self-checking bench for spike_filter_bank. Directed scenarios
//               plus randomized events/kernels checked against a behavioural
//               model of the filter bank (arrays + plain arithmetic).
//               Honours SPIKE_FILTER_SKIP_ZERO_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_filter_bank;

    localparam int NF = 16;
    localparam int NS = 27;
    localparam int NC = 10;
    localparam int NK = 4;
    localparam int IW = 4;
    localparam int KW = 2;
    localparam longint unsigned SMAX = (64'd1 << NS) - 1;
`ifdef SPIKE_FILTER_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              update_pulse = 1'b0;
    logic              in_v = 1'b0;
    logic              in_a;
    logic [IW-1:0]     in_tag = '0;
    logic [NC-1:0]     in_ct = '0;
    logic              out_v;
    logic              out_a = 1'b0;
    logic [IW-1:0]     out_idx;
    logic [NS-1:0]     out_state;
    logic [IW:0]       filts_used = '0;
    logic [NK*NS-1:0]  increment_constant = '0;
    logic [NK*NS-1:0]  decay_constant = '0;
    logic [NF*KW-1:0]  kernel_sel = '0;
    logic              sweeping;
    logic [15:0]       dropped_events;
    logic [15:0]       missed_updates;

    // Behavioural model state
    longint unsigned mdl [NF];
    longint unsigned inc_k [NK];
    longint unsigned dc_k [NK];
    int unsigned     ksel [NF];
    int unsigned     fu;
    int unsigned     mdl_drop;

    int vectors = 0;
    int miscompares = 0;

    spike_filter_bank dut (
        .clk                (clk),
        .reset              (reset),
        .update_pulse       (update_pulse),
        .in_v               (in_v),
        .in_a               (in_a),
        .in_tag             (in_tag),
        .in_ct              (in_ct),
        .out_v              (out_v),
        .out_a              (out_a),
        .out_idx            (out_idx),
        .out_state          (out_state),
        .filts_used         (filts_used),
        .increment_constant (increment_constant),
        .decay_constant     (decay_constant),
        .kernel_sel         (kernel_sel),
        .sweeping           (sweeping),
        .dropped_events     (dropped_events),
        .missed_updates     (missed_updates)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned decay(input longint unsigned s, input longint unsigned d);
        return (s * d) >> NS;
    endfunction

    // Pack model configuration onto the DUT configuration inputs.
    task automatic apply_cfg();
        for (int k = 0; k < NK; k++) begin
            increment_constant[k*NS +: NS] = NS'(inc_k[k]);
            decay_constant[k*NS +: NS]     = NS'(dc_k[k]);
        end
        for (int i = 0; i < NF; i++) kernel_sel[i*KW +: KW] = KW'(ksel[i]);
        filts_used = (IW+1)'(fu);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_v = 1'b0; update_pulse = 1'b0; out_a = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NF; i++) mdl[i] = 0;
        mdl_drop = 0;
    endtask

    // One event; expects it to be accepted in the cycle it is presented.
    task automatic send_event(input int unsigned tag, input int unsigned ct);
        longint unsigned sum;
        in_v = 1'b1; in_tag = IW'(tag); in_ct = NC'(ct);
        #1;
        chk("event_ack", in_a, 1);
        @(negedge clk);
        in_v = 1'b0;
        if (tag < fu) begin
            sum = mdl[tag] + longint'(ct) * inc_k[ksel[tag]];
            mdl[tag] = (sum > SMAX) ? SMAX : sum;
        end else begin
            mdl_drop++;
        end
    endtask

    task automatic pulse();
        update_pulse = 1'b1;
        @(negedge clk);
        update_pulse = 1'b0;
    endtask

    // Follow one sweep to completion, checking every emission against the model.
    task automatic collect_sweep();
        int n;
        bit extra;
        int lim;
        n = 0;
        while (sweeping !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("sweep_start", sweeping, 1);
        lim = (fu > NF) ? NF : fu;
        for (int i = 0; i < lim; i++) begin
            if (SKIP && mdl[i] == 0) continue;
            n = 0;
            while (out_v !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            chk("emit_valid", out_v, 1);
            chk("emit_idx", out_idx, i);
            chk("emit_state", out_state, mdl[i]);
            out_a = 1'b1;
            @(negedge clk);
            out_a = 1'b0;
            mdl[i] = decay(mdl[i], dc_k[ksel[i]]);
        end
        n = 0; extra = 1'b0;
        while (sweeping !== 1'b0 && n < 40) begin
            if (out_v === 1'b1) extra = 1'b1;
            @(negedge clk); n++;
        end
        chk("sweep_end", sweeping, 0);
        chk("no_extra_emit", extra, 0);
    endtask

    initial begin
        int n;
        bit stable_idle;
        for (int k = 0; k < NK; k++) begin inc_k[k] = 0; dc_k[k] = 0; end
        for (int i = 0; i < NF; i++) ksel[i] = 0;
        fu = 0;
        apply_cfg();
        do_reset();

        // Reset state
        #1;
        chk("rst_out_v", out_v, 0);
        chk("rst_sweeping", sweeping, 0);
        chk("rst_in_a", in_a, 0);
        chk("rst_dropped", dropped_events, 0);
        chk("rst_missed", missed_updates, 0);
        @(negedge clk);

        // Count mode
        for (int k = 0; k < NK; k++) begin inc_k[k] = 1; dc_k[k] = 0; end
        fu = 2; apply_cfg();
        repeat (3) send_event(0, 1);
        repeat (2) send_event(1, 2);
        pulse(); collect_sweep();
        pulse(); collect_sweep();

        // Decay mode
        do_reset();
        inc_k[1] = 5120; dc_k[1] = 134083577; ksel[0] = 1; fu = 1; apply_cfg();
        send_event(0, 1);
        pulse(); collect_sweep();
        pulse(); collect_sweep();

        // Saturation
        do_reset();
        inc_k[0] = 64'd1 << 26; dc_k[0] = 0; ksel[0] = 0; apply_cfg();
        send_event(0, 3);
        pulse(); collect_sweep();

        // Drop: no active filters
        do_reset();
        fu = 0; apply_cfg();
        send_event(0, 1);
        send_event(1, 1);
        #1 chk("dropped_count", dropped_events, mdl_drop);
        pulse(); collect_sweep();
        fu = 1; apply_cfg();
        pulse(); collect_sweep();

        // Backpressure with extra pulses during a stalled emission
        do_reset();
        inc_k[0] = 1000; dc_k[0] = 64'd1 << 26; fu = 2; apply_cfg();
        send_event(0, 3);
        send_event(1, 5);
        pulse();
        n = 0;
        while (out_v !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        for (int c = 0; c < 50; c++) begin
            update_pulse = (c == 5) || (c == 10);
            in_v = 1'b1; in_tag = 0; in_ct = 1;
            #1;
            chk("bp_in_a", in_a, 0);
            chk("bp_out_v", out_v, 1);
            chk("bp_out_idx", out_idx, 0);
            chk("bp_out_state", out_state, mdl[0]);
            @(negedge clk);
        end
        update_pulse = 1'b0; in_v = 1'b0;
        collect_sweep();
        collect_sweep();
        stable_idle = 1'b1;
        repeat (10) begin
            if (sweeping !== 1'b0) stable_idle = 1'b0;
            @(negedge clk);
        end
        chk("bp_single_followon", stable_idle, 1);
        chk("bp_missed", missed_updates, 1);

        // Reset during SWEEP_EMIT
        do_reset();
        inc_k[0] = 77; dc_k[0] = 100000000; fu = 3; apply_cfg();
        send_event(0, 1); send_event(1, 2); send_event(2, 3);
        pulse();
        n = 0;
        while (out_v !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_v", out_v, 0);
        chk("midrst_sweeping", sweeping, 0);
        reset = 1'b0;
        for (int i = 0; i < NF; i++) mdl[i] = 0;
        mdl_drop = 0;
        fu = 4; apply_cfg();
        pulse(); collect_sweep();

        // Randomized rounds
        do_reset();
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NK; k++) begin
                inc_k[k] = $urandom_range(0, 1 << 22);
                dc_k[k]  = ($urandom_range(0, 3) == 0) ? 0 : ($urandom & 32'h07FF_FFFF);
            end
            for (int i = 0; i < NF; i++) ksel[i] = $urandom_range(0, NK-1);
            fu = $urandom_range(0, NF);
            apply_cfg();
            repeat (12) send_event($urandom_range(0, NF-1), $urandom_range(0, 1023));
            pulse(); collect_sweep();
            #1 chk("rand_dropped", dropped_events, mdl_drop);
            @(negedge clk);
        end
        fu = NF; apply_cfg();
        pulse(); collect_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
